// File: rtl/issue_scheduler.sv
// Issue controller in front of a non-forwarding 3-stage pipeline: buffers
// instructions in a FIFO and inserts bubbles while a head source is in flight.
module issue_scheduler #(
  parameter int DEPTH     = 4,
  parameter int HAZ_DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [31:0]            in_instr,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [31:0]            instr_out,
  output logic                   issue,
  output logic                   stall,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]          mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [HAZ_DEPTH-1:0] sb_v;
  logic [4:0]           sb_dest [HAZ_DEPTH];

  logic [31:0] head;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        hazard;
  logic        head_is_nop;
  logic        head_rtype;
  logic [4:0]  head_src1;
  logic [4:0]  head_src2;
  logic [4:0]  head_dest;

  assign head     = mem[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && !hazard;

  // r0 is folded to "no register" here so the hazard and scoreboard logic never see it
  always_comb begin
    head_is_nop = (head == 32'h0);
    head_rtype  = (head[31:26] == 6'd0);
    head_src1   = head_is_nop ? 5'd0 : head[25:21];
    head_src2   = (head_is_nop || !head_rtype) ? 5'd0 : head[20:16];
    head_dest   = head_is_nop ? 5'd0 : (head_rtype ? head[15:11] : head[20:16]);
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      if (sb_v[i] &&
          (((head_src1 != 5'd0) && (sb_dest[i] == head_src1)) ||
           ((head_src2 != 5'd0) && (sb_dest[i] == head_src2))))
        hazard = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !reset)
      mem[wr_ptr] <= in_instr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      sb_v      <= '0;
      for (int i = 0; i < HAZ_DEPTH; i++) sb_dest[i] <= 5'd0;
      instr_out <= 32'h0;
      issue     <= 1'b0;
      stall     <= 1'b0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      sb_v      <= '0;
      for (int i = 0; i < HAZ_DEPTH; i++) sb_dest[i] <= 5'd0;
      instr_out <= 32'h0;
      issue     <= 1'b0;
      stall     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // entry 0 always mirrors what instr_out is about to hold
      for (int i = HAZ_DEPTH - 1; i > 0; i--) begin
        sb_v[i]    <= sb_v[i-1];
        sb_dest[i] <= sb_dest[i-1];
      end
      sb_v[0]    <= pop && (head_dest != 5'd0);
      sb_dest[0] <= pop ? head_dest : 5'd0;
      instr_out  <= pop ? head : 32'h0;
      issue      <= pop;
      stall      <= !empty && hazard;
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed vector table, hand-written corner
// sequences, and randomized traffic checked against a queue-based model.
`timescale 1ns/1ps
module tb_issue_scheduler;
  localparam int DEPTH     = 4;
  localparam int HAZ_DEPTH = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic [31:0] instr_out;
  logic        issue;
  logic        stall;
  logic [2:0]  count;

  always #5 clk = ~clk;

  issue_scheduler #(.DEPTH(DEPTH), .HAZ_DEPTH(HAZ_DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .flush(flush), .instr_out(instr_out),
    .issue(issue), .stall(stall), .count(count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_fifo[$];
  int          m_hist[$];
  logic [31:0] m_out;
  bit          m_issue;
  bit          m_stall;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] rtype(int rd, int rs, int rt);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(int rt, int rs, int imm);
    return {6'h08, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic int dest_of(logic [31:0] ins);
    if (ins == 32'h0) return 0;
    if (ins[31:26] == 6'd0) return int'(ins[15:11]);
    return int'(ins[20:16]);
  endfunction

  function automatic bit reads(logic [31:0] ins, int r);
    if (ins == 32'h0 || r == 0) return 1'b0;
    if (ins[31:26] == 6'd0) return (int'(ins[25:21]) == r) || (int'(ins[20:16]) == r);
    return int'(ins[25:21]) == r;
  endfunction

  function automatic void model_reset();
    m_fifo.delete();
    m_hist.delete();
    repeat (HAZ_DEPTH) m_hist.push_back(0);
    m_out   = 32'h0;
    m_issue = 1'b0;
    m_stall = 1'b0;
  endfunction

  // one clock edge of the issue rules: flush wins, else issue head unless a
  // source matches one of the last HAZ_DEPTH issued destinations
  function automatic void model_step(bit v, logic [31:0] ins, bit fl, output bit acc);
    bit rdy;
    bit has_head;
    bit blk;
    rdy      = m_fifo.size() < DEPTH;
    has_head = m_fifo.size() > 0;
    blk      = 1'b0;
    acc      = 1'b0;
    if (fl) begin
      model_reset();
    end else begin
      if (has_head)
        foreach (m_hist[k])
          if (reads(m_fifo[0], m_hist[k])) blk = 1'b1;
      if (has_head && !blk) begin
        m_out   = m_fifo.pop_front();
        m_issue = 1'b1;
        m_stall = 1'b0;
        m_hist.push_front(dest_of(m_out));
      end else begin
        m_out   = 32'h0;
        m_issue = 1'b0;
        m_stall = has_head;
        m_hist.push_front(0);
      end
      void'(m_hist.pop_back());
      if (v && rdy) begin
        m_fifo.push_back(ins);
        acc = 1'b1;
      end
    end
  endfunction

  task automatic tick(input bit v, input logic [31:0] ins, input bit fl, output bit acc);
    in_valid = v;
    in_instr = ins;
    flush    = fl;
    check("in_ready", 32'(in_ready), 32'(m_fifo.size() < DEPTH));
    @(posedge clk);
    model_step(v, ins, fl, acc);
    #1;
    check("instr_out", instr_out, m_out);
    check("issue", 32'(issue), 32'(m_issue));
    check("stall", 32'(stall), 32'(m_stall));
    check("count", 32'(count), 32'(m_fifo.size()));
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 1'b0, acc);
  endtask

  typedef struct {
    bit          v;
    logic [31:0] instr;
    logic [31:0] e_out;
    bit          e_issue;
    bit          e_stall;
    int          e_count;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] ia, ib, ic, id, ip, iq, z0, z1;
    logic [31:0] bp[6];
    logic [31:0] got[$];
    logic [31:0] fb0, fp, fq, ad, ae, an;
    bit acc;
    int idx;
    int maxc;
    bit saw_low;

    ia = rtype(3, 1, 2);  ib = rtype(6, 4, 5);  ic = itype(7, 8, 5);  id = rtype(9, 10, 11);
    ip = rtype(3, 1, 2);  iq = rtype(4, 3, 5);  z0 = rtype(0, 1, 2);  z1 = rtype(4, 0, 0);
    vecs[0]  = '{1'b1, ia, 32'h0, 1'b0, 1'b0, 1};
    vecs[1]  = '{1'b1, ib, ia,    1'b1, 1'b0, 1};
    vecs[2]  = '{1'b1, ic, ib,    1'b1, 1'b0, 1};
    vecs[3]  = '{1'b1, id, ic,    1'b1, 1'b0, 1};
    vecs[4]  = '{1'b0, 32'h0, id, 1'b1, 1'b0, 0};
    vecs[5]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 0};
    vecs[6]  = '{1'b1, ip, 32'h0, 1'b0, 1'b0, 1};
    vecs[7]  = '{1'b1, iq, ip,    1'b1, 1'b0, 1};
    vecs[8]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1};
    vecs[9]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1};
    vecs[10] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1};
    vecs[11] = '{1'b0, 32'h0, iq,    1'b1, 1'b0, 0};
    vecs[12] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 0};
    vecs[13] = '{1'b1, z0, 32'h0, 1'b0, 1'b0, 1};
    vecs[14] = '{1'b1, z1, z0,    1'b1, 1'b0, 1};
    vecs[15] = '{1'b0, 32'h0, z1,    1'b1, 1'b0, 0};

    reset = 1'b1; in_valid = 1'b0; in_instr = 32'h0; flush = 1'b0;
    model_reset();
    #2;
    check("rst_instr_out", instr_out, 32'h0);
    check("rst_issue", 32'(issue), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      tick(vecs[i].v, vecs[i].instr, 1'b0, acc);
      check($sformatf("vec%0d_out", i), instr_out, vecs[i].e_out);
      check($sformatf("vec%0d_issue", i), 32'(issue), 32'(vecs[i].e_issue));
      check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
    end
    idle(4);

    // backpressure: upstream holds its offer while in_ready is low
    bp[0] = rtype(3, 1, 2);
    for (int i = 1; i < 6; i++) bp[i] = itype(9 + i, 3, i);
    idx = 0; maxc = 0; saw_low = 1'b0;
    for (int cyc = 0; cyc < 60 && got.size() < 6; cyc++) begin
      tick(idx < 6, (idx < 6) ? bp[idx] : 32'h0, 1'b0, acc);
      if (acc) idx++;
      if (issue) got.push_back(instr_out);
      if (int'(count) > maxc) maxc = int'(count);
      if (!in_ready) saw_low = 1'b1;
    end
    check("bp_all_issued", 32'(got.size()), 32'd6);
    check("bp_max_count", 32'(maxc), 32'd4);
    check("bp_ready_low", 32'(saw_low), 32'd1);
    for (int i = 0; i < 6; i++)
      if (i < got.size()) check($sformatf("bp_order%0d", i), got[i], bp[i]);
    idle(4);

    // flush while stalled with r3 still in flight
    fb0 = rtype(2, 1, 1); fp = rtype(3, 2, 1); fq = rtype(4, 3, 5);
    tick(1'b1, fb0, 1'b0, acc);
    tick(1'b1, fp, 1'b0, acc);
    for (int i = 0; i < 3; i++) tick(1'b1, rtype(10 + i, 3, 3), 1'b0, acc);
    idle(2);
    check("fl_pre_count", 32'(count), 32'd3);
    check("fl_pre_stall", 32'(stall), 32'd1);
    tick(1'b1, rtype(9, 9, 9), 1'b1, acc);
    check("fl_count", 32'(count), 32'd0);
    check("fl_instr_out", instr_out, 32'h0);
    check("fl_issue", 32'(issue), 32'd0);
    check("fl_stall", 32'(stall), 32'd0);
    tick(1'b1, fq, 1'b0, acc);
    tick(1'b0, 32'h0, 1'b0, acc);
    check("fl_next_issue", 32'(issue), 32'd1);
    check("fl_next_out", instr_out, fq);
    idle(4);

    // asynchronous reset between edges while stalled
    ad = rtype(4, 3, 5); ae = rtype(6, 3, 7); an = rtype(8, 3, 1);
    tick(1'b1, ip, 1'b0, acc);
    tick(1'b1, ad, 1'b0, acc);
    tick(1'b1, ae, 1'b0, acc);
    check("ar_pre_count", 32'(count), 32'd2);
    check("ar_pre_stall", 32'(stall), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("ar_count", 32'(count), 32'd0);
    check("ar_stall", 32'(stall), 32'd0);
    check("ar_issue", 32'(issue), 32'd0);
    check("ar_instr_out", instr_out, 32'h0);
    check("ar_in_ready", 32'(in_ready), 32'd1);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    tick(1'b1, an, 1'b0, acc);
    check("ar_push_count", 32'(count), 32'd1);
    check("ar_push_issue", 32'(issue), 32'd0);
    tick(1'b0, 32'h0, 1'b0, acc);
    check("ar_new_issue", 32'(issue), 32'd1);
    check("ar_new_out", instr_out, an);
    idle(4);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r;
      int sel;
      sel = $urandom_range(0, 7);
      if (sel == 0)
        r = 32'h0;
      else if (sel < 5)
        r = rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      else
        r = itype($urandom_range(0, 7), $urandom_range(0, 7), int'($urandom_range(0, 65535)));
      tick($urandom_range(0, 3) != 0, r, $urandom_range(0, 39) == 0, acc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
